// File: rtl/rf_spill_fill_ctrl_pkg.sv
// Shared types and default sizing for the register-window spill/fill controller.
package rf_spill_fill_ctrl_pkg;

  localparam int NBITS = 64;
  localparam int N = 3;
  localparam int SPILL_WORDS = 2 * N;
  localparam int STACK_WINDOWS = 8;

  typedef enum logic [1:0] {
    IDLE,
    SPILL,
    FILL
  } sf_state_t;

endpackage

// File: rtl/rf_spill_fill_ctrl_if.sv
// Spill/fill handshake bundle between the windowed register file (master)
// and the window stack controller (slave).
interface rf_spill_fill_ctrl_if #(
  parameter int NBITS = 64
);
  logic             spill_valid;
  logic [NBITS-1:0] spill_data;
  logic             spill_last;
  logic             spill_ready;
  logic             fill_req;
  logic             fill_valid;
  logic [NBITS-1:0] fill_data;
  logic             fill_last;
  logic             fill_ready;

  modport master (
    output spill_valid,
    output spill_data,
    output spill_last,
    input  spill_ready,
    output fill_req,
    input  fill_valid,
    input  fill_data,
    input  fill_last,
    output fill_ready
  );

  modport slave (
    input  spill_valid,
    input  spill_data,
    input  spill_last,
    output spill_ready,
    input  fill_req,
    output fill_valid,
    output fill_data,
    output fill_last,
    input  fill_ready
  );
endinterface

// File: rtl/rf_spill_fill_ctrl_mem.sv
// Single-port synchronous RAM for spilled windows; read data is registered
// and holds its value on cycles without a read.
module rf_spill_mem #(
  parameter int NBITS = 64,
  parameter int DEPTH = 48,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [NBITS-1:0] wdata,
  output logic [NBITS-1:0] rdata
);

  logic [NBITS-1:0] mem_q [DEPTH];
  logic [NBITS-1:0] rdata_q;
  logic [NBITS-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Only the output register is reset; stored windows survive reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rf_spill_fill_ctrl.sv
// LIFO window stack behind the register file: stores spilled IN+LOCAL
// windows and streams the most recent one back on a fill request.
module rf_spill_fill_ctrl #(
  parameter int NBITS = rf_spill_fill_ctrl_pkg::NBITS,
  parameter int N = rf_spill_fill_ctrl_pkg::N,
  parameter int STACK_WINDOWS = rf_spill_fill_ctrl_pkg::STACK_WINDOWS,
  localparam int CW = $clog2(STACK_WINDOWS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  rf_spill_fill_ctrl_if.slave sf,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      win_count,
  output logic               err_overflow,
  output logic               err_underflow,
  output logic               err_protocol
);
  import rf_spill_fill_ctrl_pkg::*;

  localparam int W = 2 * N;
  localparam int DEPTH = STACK_WINDOWS * W;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(W + 1);

  sf_state_t state_q, state_d;
  logic [CW-1:0] wc_q, wc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic fv_q, fv_d;
  logic fl_q, fl_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic of_q, of_d;
  logic uf_q, uf_d;
  logic pe_q, pe_d;

  logic             spill_ready_c;
  logic             spill_hs;
  logic             at_end;
  logic             mem_we;
  logic             mem_re;
  logic [AW-1:0]    mem_addr;
  logic [NBITS-1:0] mem_rdata;
  logic [CW-1:0]    top_win;

  rf_spill_mem #(
    .NBITS(NBITS),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (mem_we),
    .re   (mem_re),
    .addr (mem_addr),
    .wdata(sf.spill_data),
    .rdata(mem_rdata)
  );

  always_comb begin
    spill_ready_c = 1'b0;
    unique case (state_q)
      IDLE:    spill_ready_c = !full_q && !sf.fill_req;
      SPILL:   spill_ready_c = 1'b1;
      default: spill_ready_c = 1'b0;
    endcase
    if (!rst_n) begin
      spill_ready_c = 1'b0;
    end
  end

  assign spill_hs = sf.spill_valid && spill_ready_c;
  assign at_end   = (idx_q == IW'(W - 1));
  assign top_win  = wc_q - CW'(1);

  always_comb begin
    state_d  = state_q;
    wc_d     = wc_q;
    idx_d    = idx_q;
    fv_d     = fv_q;
    fl_d     = fl_q;
    of_d     = 1'b0;
    uf_d     = 1'b0;
    pe_d     = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = '0;

    unique case (state_q)
      IDLE, SPILL: begin
        if (state_q == IDLE && sf.fill_req) begin
          if (empty_q) begin
            uf_d = 1'b1;
          end else begin
            state_d  = FILL;
            mem_re   = 1'b1;
            mem_addr = AW'(int'(top_win) * W);
            idx_d    = IW'(1);
            fv_d     = 1'b1;
            fl_d     = (W == 1);
          end
        end else if (state_q == IDLE && sf.spill_valid && full_q) begin
          of_d = 1'b1;
        end else if (spill_hs) begin
          mem_we   = 1'b1;
          mem_addr = AW'(int'(wc_q) * W + int'(idx_q));
          // A misplaced last marker drops the partial window.
          if (at_end && sf.spill_last) begin
            wc_d    = wc_q + CW'(1);
            idx_d   = '0;
            state_d = IDLE;
          end else if (at_end || sf.spill_last) begin
            pe_d    = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = SPILL;
          end
        end
      end
      FILL: begin
        if (fv_q && sf.fill_ready) begin
          if (fl_q) begin
            wc_d    = top_win;
            fv_d    = 1'b0;
            fl_d    = 1'b0;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            mem_re   = 1'b1;
            mem_addr = AW'(int'(top_win) * W + int'(idx_q));
            idx_d    = idx_q + IW'(1);
            fl_d     = at_end;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    full_d  = (wc_d == CW'(STACK_WINDOWS));
    empty_d = (wc_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wc_q    <= '0;
      idx_q   <= '0;
      fv_q    <= 1'b0;
      fl_q    <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      of_q    <= 1'b0;
      uf_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      idx_q   <= idx_d;
      fv_q    <= fv_d;
      fl_q    <= fl_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      of_q    <= of_d;
      uf_q    <= uf_d;
      pe_q    <= pe_d;
    end
  end

  assign sf.spill_ready = spill_ready_c;
  assign sf.fill_valid  = fv_q;
  assign sf.fill_last   = fl_q;
  assign sf.fill_data   = mem_rdata;
  assign full           = full_q;
  assign empty          = empty_q;
  assign win_count      = wc_q;
  assign err_overflow   = of_q;
  assign err_underflow  = uf_q;
  assign err_protocol   = pe_q;

endmodule

// File: tb/tb_rf_spill_fill_ctrl.sv
// Directed self-checking bench for rf_spill_fill_ctrl.
module tb_rf_spill_fill_ctrl;

  localparam int NB = 64;
  localparam int WW = 6;

  logic       clk;
  logic       rst_n;
  logic       full;
  logic       empty;
  logic [3:0] win_count;
  logic       err_overflow;
  logic       err_underflow;
  logic       err_protocol;

  int checks;
  int failures;

  rf_spill_fill_ctrl_if #(.NBITS(NB)) sf ();

  rf_spill_fill_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sf           (sf),
    .full         (full),
    .empty        (empty),
    .win_count    (win_count),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
    .err_protocol (err_protocol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spill_words(input logic [NB-1:0] base,
                             input int n, input int last_at);
    int cnt;
    for (int i = 0; i < n; i++) begin
      sf.spill_valid = 1'b1;
      sf.spill_data  = base + NB'(i);
      sf.spill_last  = (i == last_at);
      #0;
      cnt = 0;
      while (!sf.spill_ready && cnt < 20) begin
        tick();
        cnt++;
      end
      if (!sf.spill_ready) begin
        checks++;
        failures++;
        $display("FAIL spill_ready_timeout word=%0d got=0 want=1", i);
      end
      tick();
    end
    sf.spill_valid = 1'b0;
    sf.spill_last  = 1'b0;
  endtask

  task automatic do_fill(output logic [NB-1:0] d [WW],
                         output logic l [WW],
                         output logic v [WW]);
    sf.fill_req   = 1'b1;
    sf.fill_ready = 1'b1;
    tick();
    sf.fill_req = 1'b0;
    for (int i = 0; i < WW; i++) begin
      d[i] = sf.fill_data;
      l[i] = sf.fill_last;
      v[i] = sf.fill_valid;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sf.spill_valid = 1'b1;
    sf.spill_data  = '0;
    sf.spill_last  = 1'b0;
    sf.fill_req    = 1'b0;
    sf.fill_ready  = 1'b1;
    tick();
    tick();
    checks++;
    if (sf.spill_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_spill_ready got=%b want=0", sf.spill_ready);
    end
    sf.spill_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (win_count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL rst_flags got wc=%0d e=%b f=%b want wc=0 e=1 f=0",
               win_count, empty, full);
    end
    checks++;
    if (sf.fill_valid !== 1'b0 || sf.fill_last !== 1'b0 ||
        sf.fill_data !== 64'd0) begin
      failures++;
      $display("FAIL rst_fill got v=%b l=%b d=%h want 0", sf.fill_valid,
               sf.fill_last, sf.fill_data);
    end
    checks++;
    if ({err_overflow, err_underflow, err_protocol} !== 3'b000) begin
      failures++;
      $display("FAIL rst_err got=%b want=000",
               {err_overflow, err_underflow, err_protocol});
    end
  endtask

  task automatic test_round_trip();
    logic [NB-1:0] d [WW];
    logic l [WW];
    logic v [WW];
    spill_words(64'h10, WW, WW - 1);
    checks++;
    if (win_count !== 4'd1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL rt_spill got wc=%0d e=%b want wc=1 e=0", win_count, empty);
    end
    do_fill(d, l, v);
    for (int i = 0; i < WW; i++) begin
      checks++;
      if (v[i] !== 1'b1 || d[i] !== 64'h10 + NB'(i) ||
          l[i] !== (i == WW - 1)) begin
        failures++;
        $display("FAIL rt_word%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, v[i], d[i], l[i], 64'h10 + NB'(i), i == WW - 1);
      end
    end
    checks++;
    if (win_count !== 4'd0 || empty !== 1'b1 || sf.fill_valid !== 1'b0) begin
      failures++;
      $display("FAIL rt_end got wc=%0d e=%b fv=%b want wc=0 e=1 fv=0",
               win_count, empty, sf.fill_valid);
    end
  endtask

  task automatic test_lifo();
    logic [NB-1:0] d [WW];
    logic l [WW];
    logic v [WW];
    spill_words(64'hA0, WW, WW - 1);
    spill_words(64'hB0, WW, WW - 1);
    checks++;
    if (win_count !== 4'd2) begin
      failures++;
      $display("FAIL lifo_wc2 got=%0d want=2", win_count);
    end
    do_fill(d, l, v);
    for (int i = 0; i < WW; i++) begin
      checks++;
      if (d[i] !== 64'hB0 + NB'(i) || v[i] !== 1'b1) begin
        failures++;
        $display("FAIL lifo_b%0d got d=%h v=%b want d=%h v=1",
                 i, d[i], v[i], 64'hB0 + NB'(i));
      end
    end
    checks++;
    if (win_count !== 4'd1) begin
      failures++;
      $display("FAIL lifo_wc1 got=%0d want=1", win_count);
    end
    do_fill(d, l, v);
    for (int i = 0; i < WW; i++) begin
      checks++;
      if (d[i] !== 64'hA0 + NB'(i) || v[i] !== 1'b1) begin
        failures++;
        $display("FAIL lifo_a%0d got d=%h v=%b want d=%h v=1",
                 i, d[i], v[i], 64'hA0 + NB'(i));
      end
    end
    checks++;
    if (win_count !== 4'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL lifo_wc0 got wc=%0d e=%b want wc=0 e=1", win_count, empty);
    end
  endtask

  task automatic test_full_overflow();
    logic [NB-1:0] d [WW];
    logic l [WW];
    logic v [WW];
    for (int k = 0; k < 8; k++) begin
      spill_words(64'h100 * NB'(k + 1), WW, WW - 1);
    end
    checks++;
    if (full !== 1'b1 || win_count !== 4'd8) begin
      failures++;
      $display("FAIL full_flag got f=%b wc=%0d want f=1 wc=8", full, win_count);
    end
    sf.spill_valid = 1'b1;
    sf.spill_data  = 64'hDEAD;
    sf.spill_last  = 1'b0;
    #0;
    checks++;
    if (sf.spill_ready !== 1'b0) begin
      failures++;
      $display("FAIL ovf_ready got=%b want=0", sf.spill_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (err_overflow !== 1'b1 || sf.spill_ready !== 1'b0) begin
        failures++;
        $display("FAIL ovf_pulse%0d got e=%b r=%b want e=1 r=0",
                 k, err_overflow, sf.spill_ready);
      end
    end
    sf.spill_valid = 1'b0;
    tick();
    checks++;
    if (err_overflow !== 1'b0 || win_count !== 4'd8) begin
      failures++;
      $display("FAIL ovf_end got e=%b wc=%0d want e=0 wc=8",
               err_overflow, win_count);
    end
    for (int k = 8; k >= 1; k--) begin
      do_fill(d, l, v);
      checks++;
      if (d[0] !== 64'h100 * NB'(k) || d[WW-1] !== 64'h100 * NB'(k) + 5 ||
          l[WW-1] !== 1'b1) begin
        failures++;
        $display("FAIL drain%0d got d0=%h d5=%h l=%b want d0=%h d5=%h l=1",
                 k, d[0], d[WW-1], l[WW-1], 64'h100 * NB'(k),
                 64'h100 * NB'(k) + 5);
      end
    end
    checks++;
    if (win_count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL drain_end got wc=%0d e=%b f=%b want 0 1 0",
               win_count, empty, full);
    end
  endtask

  task automatic test_underflow_priority();
    logic [NB-1:0] d [WW];
    logic l [WW];
    logic v [WW];
    sf.fill_req = 1'b1;
    tick();
    sf.fill_req = 1'b0;
    checks++;
    if (err_underflow !== 1'b1 || sf.fill_valid !== 1'b0) begin
      failures++;
      $display("FAIL udf_pulse got e=%b fv=%b want e=1 fv=0",
               err_underflow, sf.fill_valid);
    end
    tick();
    checks++;
    if (err_underflow !== 1'b0 || sf.fill_valid !== 1'b0) begin
      failures++;
      $display("FAIL udf_clear got e=%b fv=%b want e=0 fv=0",
               err_underflow, sf.fill_valid);
    end
    spill_words(64'h30, WW, WW - 1);
    sf.fill_req    = 1'b1;
    sf.fill_ready  = 1'b1;
    sf.spill_valid = 1'b1;
    sf.spill_data  = 64'hEE;
    sf.spill_last  = 1'b0;
    #0;
    checks++;
    if (sf.spill_ready !== 1'b0) begin
      failures++;
      $display("FAIL prio_ready got=%b want=0", sf.spill_ready);
    end
    tick();
    sf.fill_req    = 1'b0;
    sf.spill_valid = 1'b0;
    for (int i = 0; i < WW; i++) begin
      checks++;
      if (sf.fill_valid !== 1'b1 || sf.fill_data !== 64'h30 + NB'(i)) begin
        failures++;
        $display("FAIL prio_word%0d got v=%b d=%h want v=1 d=%h",
                 i, sf.fill_valid, sf.fill_data, 64'h30 + NB'(i));
      end
      tick();
    end
    checks++;
    if (win_count !== 4'd0 || sf.spill_ready !== 1'b1) begin
      failures++;
      $display("FAIL prio_end got wc=%0d r=%b want wc=0 r=1",
               win_count, sf.spill_ready);
    end
    do_fill(d, l, v);
    checks++;
    if (v[0] !== 1'b0 || err_underflow !== 1'b0) begin
      failures++;
      $display("FAIL prio_nospill got fv=%b want fv=0", v[0]);
    end
  endtask

  task automatic test_backpressure_protocol();
    spill_words(64'h50, WW, WW - 1);
    sf.fill_req   = 1'b1;
    sf.fill_ready = 1'b1;
    tick();
    sf.fill_req = 1'b0;
    tick();
    tick();
    sf.fill_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sf.fill_valid !== 1'b1 || sf.fill_data !== 64'h52 ||
          sf.fill_last !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b d=%h l=%b want v=1 d=52 l=0",
                 k, sf.fill_valid, sf.fill_data, sf.fill_last);
      end
      tick();
    end
    sf.fill_ready = 1'b1;
    for (int i = 2; i < WW; i++) begin
      checks++;
      if (sf.fill_data !== 64'h50 + NB'(i) || sf.fill_last !== (i == WW - 1)) begin
        failures++;
        $display("FAIL bp_word%0d got d=%h l=%b want d=%h l=%b", i,
                 sf.fill_data, sf.fill_last, 64'h50 + NB'(i), i == WW - 1);
      end
      tick();
    end
    checks++;
    if (win_count !== 4'd0 || sf.fill_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_end got wc=%0d fv=%b want 0 0", win_count, sf.fill_valid);
    end
    spill_words(64'h60, WW, WW - 1);
    spill_words(64'hC0, 4, 3);
    checks++;
    if (err_protocol !== 1'b1 || win_count !== 4'd1) begin
      failures++;
      $display("FAIL proto_pulse got e=%b wc=%0d want e=1 wc=1",
               err_protocol, win_count);
    end
    tick();
    checks++;
    if (err_protocol !== 1'b0 || sf.spill_ready !== 1'b1) begin
      failures++;
      $display("FAIL proto_clear got e=%b r=%b want e=0 r=1",
               err_protocol, sf.spill_ready);
    end
    spill_words(64'hD0, WW, -1);
    checks++;
    if (err_protocol !== 1'b1 || win_count !== 4'd1) begin
      failures++;
      $display("FAIL proto_nolast got e=%b wc=%0d want e=1 wc=1",
               err_protocol, win_count);
    end
  endtask

  task automatic test_reset_mid_spill();
    logic [NB-1:0] d [WW];
    logic l [WW];
    logic v [WW];
    spill_words(64'hF0, 3, -1);
    rst_n = 1'b0;
    sf.spill_valid = 1'b1;
    sf.spill_data  = 64'hF3;
    #0;
    checks++;
    if (sf.spill_ready !== 1'b0) begin
      failures++;
      $display("FAIL rms_ready got=%b want=0", sf.spill_ready);
    end
    tick();
    tick();
    sf.spill_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (win_count !== 4'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL rms_wc got wc=%0d e=%b want wc=0 e=1", win_count, empty);
    end
    spill_words(64'h70, WW, WW - 1);
    do_fill(d, l, v);
    for (int i = 0; i < WW; i++) begin
      checks++;
      if (v[i] !== 1'b1 || d[i] !== 64'h70 + NB'(i) ||
          l[i] !== (i == WW - 1)) begin
        failures++;
        $display("FAIL rms_word%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, v[i], d[i], l[i], 64'h70 + NB'(i), i == WW - 1);
      end
    end
    checks++;
    if (win_count !== 4'd0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL rms_end got wc=%0d e=%b want wc=0 e=1", win_count, empty);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_round_trip();
    test_lifo();
    test_full_overflow();
    test_underflow_priority();
    test_backpressure_protocol();
    test_reset_mid_spill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
